// File: rtl/rx_ts_decoder.sv
// Per-lane receive TS1/TS2 ordered-set decoder for the 8-bit PIPE stream.
// Extracts training fields, counts consecutive identical sets, skips SKP.
module rx_ts_decoder #(
  parameter int MAX_COUNT   = 16,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                   pclk,
  input  logic                   reset_n,
  input  logic [7:0]             RxData,
  input  logic                   RxDataK,
  input  logic                   RxValid,
  input  logic                   clear,
  output logic                   os_valid,
  output logic                   os_error,
  output logic [1:0]             os_type,
  output logic [7:0]             link_number,
  output logic                   link_pad,
  output logic [7:0]             lane_number,
  output logic                   lane_pad,
  output logic [7:0]             n_fts,
  output logic [7:0]             rate_id,
  output logic [7:0]             train_ctrl,
  output logic [COUNT_WIDTH-1:0] ts_count
);

  typedef enum logic [2:0] {
    HUNT, LINK, LANE, NFTS, RATE, CTRL, ID, SKIP
  } state_t;

  state_t     state, state_nx;
  logic [3:0] idx, idx_nx;
  logic [7:0] st_link, st_link_nx;
  logic       st_lpad, st_lpad_nx;
  logic [7:0] st_lane, st_lane_nx;
  logic       st_npad, st_npad_nx;
  logic [7:0] st_nfts, st_nfts_nx;
  logic [7:0] st_rate, st_rate_nx;
  logic [7:0] st_ctrl, st_ctrl_nx;
  logic [7:0] st_id, st_id_nx;
  logic       hist;
  logic       done, bad;

  logic is_com, is_pad, is_skp, is_id;
  assign is_com = RxDataK && (RxData == 8'hBC);
  assign is_pad = RxDataK && (RxData == 8'hF7);
  assign is_skp = RxDataK && (RxData == 8'h1C);
  assign is_id  = !RxDataK && (RxData == 8'h4A || RxData == 8'h45);

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    st_link_nx = st_link;
    st_lpad_nx = st_lpad;
    st_lane_nx = st_lane;
    st_npad_nx = st_npad;
    st_nfts_nx = st_nfts;
    st_rate_nx = st_rate;
    st_ctrl_nx = st_ctrl;
    st_id_nx   = st_id;
    done       = 1'b0;
    bad        = 1'b0;
    if (RxValid) begin
      unique case (state)
        HUNT: if (is_com) state_nx = LINK;
        LINK: begin
          if (!RxDataK || is_pad) begin
            st_link_nx = RxData;
            st_lpad_nx = is_pad;
            state_nx   = LANE;
          end else if (is_skp) begin
            state_nx = SKIP;
          end else begin
            bad = 1'b1;
          end
        end
        LANE: begin
          if (!RxDataK || is_pad) begin
            st_lane_nx = RxData;
            st_npad_nx = is_pad;
            state_nx   = NFTS;
          end else begin
            bad = 1'b1;
          end
        end
        NFTS: begin
          st_nfts_nx = RxData;
          state_nx   = RATE;
          bad        = RxDataK;
        end
        RATE: begin
          st_rate_nx = RxData;
          state_nx   = CTRL;
          bad        = RxDataK;
        end
        CTRL: begin
          st_ctrl_nx = RxData;
          idx_nx     = 4'd0;
          state_nx   = ID;
          bad        = RxDataK;
        end
        ID: begin
          if (idx == 4'd0 ? is_id
              : (!RxDataK && RxData == st_id)) begin
            if (idx == 4'd0) st_id_nx = RxData;
            if (idx == 4'd9) begin
              done     = 1'b1;
              state_nx = HUNT;
            end else begin
              idx_nx = idx + 4'd1;
            end
          end else begin
            bad = 1'b1;
          end
        end
        SKIP: begin
          if (is_com)       state_nx = LINK;
          else if (!is_skp) state_nx = HUNT;
        end
        default: state_nx = HUNT;
      endcase
      // A COM inside a set restarts parsing rather than hunting again
      if (bad) state_nx = is_com ? LINK : HUNT;
    end
  end

  logic same;
  assign same = hist
    && os_type == ((st_id == 8'h4A) ? 2'b01 : 2'b10)
    && link_number == st_link && link_pad == st_lpad
    && lane_number == st_lane && lane_pad == st_npad
    && n_fts == st_nfts && rate_id == st_rate
    && train_ctrl == st_ctrl;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= HUNT;
      idx     <= '0;
      st_link <= '0;
      st_lpad <= 1'b0;
      st_lane <= '0;
      st_npad <= 1'b0;
      st_nfts <= '0;
      st_rate <= '0;
      st_ctrl <= '0;
      st_id   <= '0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      st_link <= st_link_nx;
      st_lpad <= st_lpad_nx;
      st_lane <= st_lane_nx;
      st_npad <= st_npad_nx;
      st_nfts <= st_nfts_nx;
      st_rate <= st_rate_nx;
      st_ctrl <= st_ctrl_nx;
      st_id   <= st_id_nx;
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      os_valid    <= 1'b0;
      os_error    <= 1'b0;
      os_type     <= 2'b00;
      link_number <= '0;
      link_pad    <= 1'b0;
      lane_number <= '0;
      lane_pad    <= 1'b0;
      n_fts       <= '0;
      rate_id     <= '0;
      train_ctrl  <= '0;
      ts_count    <= '0;
      hist        <= 1'b0;
    end else begin
      os_valid <= done;
      os_error <= bad;
      if (done) begin
        os_type     <= (st_id == 8'h4A) ? 2'b01 : 2'b10;
        link_number <= st_link;
        link_pad    <= st_lpad;
        lane_number <= st_lane;
        lane_pad    <= st_npad;
        n_fts       <= st_nfts;
        rate_id     <= st_rate;
        train_ctrl  <= st_ctrl;
        hist        <= 1'b1;
        if (same && !clear)
          ts_count <= (ts_count == COUNT_WIDTH'(MAX_COUNT))
                      ? ts_count : ts_count + 1'b1;
        else
          ts_count <= COUNT_WIDTH'(1);
      end else if (bad || clear) begin
        ts_count <= '0;
        hist     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_ts_decoder.sv
// Bench for rx_ts_decoder: directed TS table, corner sequences and
// randomized symbol streams checked against a set-level reference model.
module tb_rx_ts_decoder;
  localparam int MAXC = 16;
  localparam logic [8:0] COM = 9'h1BC;
  localparam logic [8:0] PAD = 9'h1F7;
  localparam logic [8:0] SKP = 9'h11C;
  localparam logic [8:0] T1  = 9'h04A;
  localparam logic [8:0] T2  = 9'h045;

  logic       pclk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] RxData = '0;
  logic       RxDataK = 1'b0;
  logic       RxValid = 1'b0;
  logic       clear = 1'b0;
  logic       os_valid, os_error, link_pad, lane_pad;
  logic [1:0] os_type;
  logic [7:0] link_number, lane_number, n_fts, rate_id, train_ctrl;
  logic [4:0] ts_count;

  rx_ts_decoder #(.MAX_COUNT(16), .COUNT_WIDTH(5)) dut (
    .pclk(pclk), .reset_n(reset_n), .RxData(RxData),
    .RxDataK(RxDataK), .RxValid(RxValid), .clear(clear),
    .os_valid(os_valid), .os_error(os_error), .os_type(os_type),
    .link_number(link_number), .link_pad(link_pad),
    .lane_number(lane_number), .lane_pad(lane_pad),
    .n_fts(n_fts), .rate_id(rate_id), .train_ctrl(train_ctrl),
    .ts_count(ts_count)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  logic saw_v, saw_e;

  // Reference model: symbols of the current set are kept in a queue
  int         m_mode;
  logic [8:0] q[$];
  logic       m_hist;
  logic       e_valid, e_err, e_lpad, e_npad;
  logic [1:0] e_type;
  logic [7:0] e_link, e_lane, e_nfts, e_rate, e_ctrl;
  int         e_cnt;

  function automatic void model_reset();
    m_mode = 0; q.delete(); m_hist = 0;
    e_valid = 0; e_err = 0; e_lpad = 0; e_npad = 0; e_type = 0;
    e_link = 0; e_lane = 0; e_nfts = 0; e_rate = 0; e_ctrl = 0;
    e_cnt = 0;
  endfunction

  function automatic bit sym_ok(int pos, logic [8:0] s);
    if (pos <= 2) return !s[8] || s == PAD;
    if (pos <= 5) return !s[8];
    if (pos == 6) return s == T1 || s == T2;
    return s == q[6];
  endfunction

  function automatic void model_step(logic [7:0] d, logic k,
                                     logic v, logic clr);
    logic [8:0] s;
    bit done, bad, same;
    s = {k, d};
    done = 0; bad = 0;
    e_valid = 0; e_err = 0;
    if (v) begin
      if (m_mode == 0) begin
        if (s == COM) begin q = {s}; m_mode = 1; end
      end else if (m_mode == 2) begin
        if (s == COM) begin q = {s}; m_mode = 1; end
        else if (s != SKP) m_mode = 0;
      end else if (q.size() == 1 && s == SKP) begin
        m_mode = 2;
      end else if (sym_ok(q.size(), s)) begin
        q.push_back(s);
        if (q.size() == 16) begin done = 1; m_mode = 0; end
      end else begin
        bad = 1;
        if (s == COM) q = {s};
        else m_mode = 0;
      end
    end
    if (done) begin
      same = m_hist
        && e_type == ((q[6] == T1) ? 2'b01 : 2'b10)
        && e_link == q[1][7:0] && e_lpad == (q[1] == PAD)
        && e_lane == q[2][7:0] && e_npad == (q[2] == PAD)
        && e_nfts == q[3][7:0] && e_rate == q[4][7:0]
        && e_ctrl == q[5][7:0];
      e_type = (q[6] == T1) ? 2'b01 : 2'b10;
      e_link = q[1][7:0]; e_lpad = (q[1] == PAD);
      e_lane = q[2][7:0]; e_npad = (q[2] == PAD);
      e_nfts = q[3][7:0]; e_rate = q[4][7:0]; e_ctrl = q[5][7:0];
      e_cnt = (same && !clr) ? ((e_cnt < MAXC) ? e_cnt + 1 : MAXC) : 1;
      m_hist = 1; e_valid = 1;
    end else if (bad || clr) begin
      e_err = bad; e_cnt = 0; m_hist = 0;
    end
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic check_all();
    chk("os_valid", os_valid, e_valid);
    chk("os_error", os_error, e_err);
    chk("os_type", os_type, e_type);
    chk("link_pad", link_pad, e_lpad);
    chk("lane_pad", lane_pad, e_npad);
    if (!e_lpad) chk("link_number", link_number, e_link);
    if (!e_npad) chk("lane_number", lane_number, e_lane);
    chk("n_fts", n_fts, e_nfts);
    chk("rate_id", rate_id, e_rate);
    chk("train_ctrl", train_ctrl, e_ctrl);
    chk("ts_count", ts_count, e_cnt);
  endtask

  task automatic step(logic [7:0] d, logic k, logic v, logic clr);
    @(negedge pclk);
    RxData = d; RxDataK = k; RxValid = v; clear = clr;
    @(posedge pclk);
    model_step(d, k, v, clr);
    #1;
    check_all();
    saw_v |= os_valid;
    saw_e |= os_error;
  endtask

  typedef struct {
    logic [8:0] id;
    logic       lpad;
    logic [7:0] link;
    logic       npad;
    logic [7:0] lane;
    logic [7:0] nfts, rate, ctrl;
    int         bad_idx;
    logic [7:0] bad_val;
    logic       exp_v, exp_e;
    int         exp_cnt;
    logic [1:0] exp_type;
  } vec_t;

  function automatic vec_t mk(logic [8:0] id, logic lp, logic [7:0] lk,
      logic np, logic [7:0] ln, logic [7:0] nf, logic [7:0] rt,
      logic [7:0] ct, int bi, logic [7:0] bv, logic ev, logic ee,
      int ec, logic [1:0] et);
    vec_t v;
    v.id = id; v.lpad = lp; v.link = lk; v.npad = np; v.lane = ln;
    v.nfts = nf; v.rate = rt; v.ctrl = ct; v.bad_idx = bi;
    v.bad_val = bv; v.exp_v = ev; v.exp_e = ee; v.exp_cnt = ec;
    v.exp_type = et;
    return v;
  endfunction

  logic [8:0] sq[$];

  task automatic build(vec_t v);
    sq.delete();
    sq.push_back(COM);
    sq.push_back(v.lpad ? PAD : {1'b0, v.link});
    sq.push_back(v.npad ? PAD : {1'b0, v.lane});
    sq.push_back({1'b0, v.nfts});
    sq.push_back({1'b0, v.rate});
    sq.push_back({1'b0, v.ctrl});
    for (int i = 0; i < 10; i++)
      sq.push_back(i == v.bad_idx ? {1'b0, v.bad_val} : v.id);
  endtask

  task automatic play(bit gaps, bit clr_last, bit rclr);
    bit c;
    foreach (sq[i]) begin
      if (gaps)
        repeat ($urandom_range(0, 2))
          step(8'($urandom), 1'($urandom), 1'b0, 1'b0);
      c = (clr_last && i == sq.size() - 1)
          || (rclr && $urandom_range(0, 99) < 3);
      step(sq[i][7:0], sq[i][8], 1'b1, c);
    end
  endtask

  function automatic logic [8:0] rnd_sym();
    case ($urandom_range(0, 6))
      0: return COM;
      1: return PAD;
      2: return SKP;
      3: return T1;
      4: return T2;
      5: return {1'b1, 8'($urandom)};
      default: return {1'b0, 8'($urandom)};
    endcase
  endfunction

  vec_t tbl[10];
  vec_t v;
  logic [8:0] tmp[$];

  initial begin
    tbl[0] = mk(T1, 1, 0, 1, 0, 8'h10, 8'h02, 8'h00, -1, 0, 1, 0, 1, 2'b01);
    tbl[1] = mk(T1, 1, 0, 1, 0, 8'h10, 8'h02, 8'h00, -1, 0, 1, 0, 2, 2'b01);
    tbl[2] = mk(T1, 1, 0, 1, 0, 8'h10, 8'h02, 8'h00, -1, 0, 1, 0, 3, 2'b01);
    tbl[3] = mk(T1, 0, 5, 0, 3, 8'h10, 8'h02, 8'h00, -1, 0, 1, 0, 1, 2'b01);
    tbl[4] = mk(T2, 0, 5, 0, 3, 8'h10, 8'h02, 8'h00, -1, 0, 1, 0, 1, 2'b10);
    tbl[5] = mk(T1, 0, 5, 0, 3, 8'h10, 8'h02, 8'h00, -1, 0, 1, 0, 1, 2'b01);
    tbl[6] = mk(T1, 0, 5, 0, 3, 8'h10, 8'h02, 8'h00, 4, 8'h4B, 0, 1, 0, 2'b01);
    tbl[7] = mk(T1, 0, 5, 0, 3, 8'h10, 8'h02, 8'h00, -1, 0, 1, 0, 1, 2'b01);
    tbl[8] = mk(T1, 0, 5, 0, 3, 8'h10, 8'h02, 8'h01, -1, 0, 1, 0, 1, 2'b01);
    tbl[9] = mk(T1, 0, 5, 0, 3, 8'h10, 8'h02, 8'h01, -1, 0, 1, 0, 2, 2'b01);

    model_reset();
    saw_v = 0; saw_e = 0;
    repeat (3) @(negedge pclk);
    check_all();
    reset_n = 1'b1;

    // Reset mid-set after a completed set: outputs return to zero
    build(mk(T2, 0, 8'h22, 0, 8'h11, 8'h33, 8'h44, 8'h08,
             -1, 0, 1, 0, 1, 2'b10));
    play(0, 0, 0);
    chk("pre_reset_cnt", ts_count, 1);
    sq = sq[0:4];
    play(0, 0, 0);
    @(negedge pclk);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge pclk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      saw_v = 0; saw_e = 0;
      build(tbl[i]);
      play(0, 0, 0);
      chk("tbl_valid", saw_v, tbl[i].exp_v);
      chk("tbl_error", saw_e, tbl[i].exp_e);
      chk("tbl_count", ts_count, tbl[i].exp_cnt);
      chk("tbl_type", os_type, tbl[i].exp_type);
      if (!tbl[i].lpad) chk("tbl_link", link_number, tbl[i].link);
      if (!tbl[i].npad) chk("tbl_lane", lane_number, tbl[i].lane);
    end

    // COM at ID index 2 restarts; the following 15 symbols complete
    build(tbl[7]);
    tmp = sq;
    sq = tmp[0:7];
    sq.push_back(COM);
    for (int i = 1; i < 16; i++) sq.push_back(tmp[i]);
    saw_v = 0; saw_e = 0;
    play(0, 0, 0);
    chk("restart_err", saw_e, 1);
    chk("restart_valid", saw_v, 1);
    chk("restart_cnt", ts_count, 1);

    // TS2, COM + 3 SKP, TS2 with gaps
    step(8'h00, 1'b0, 1'b0, 1'b1);
    v = mk(T2, 0, 8'h07, 0, 8'h01, 8'h20, 8'h02, 8'h04,
           -1, 0, 1, 0, 1, 2'b10);
    saw_v = 0; saw_e = 0;
    build(v);
    play(1, 0, 0);
    sq = {COM, SKP, SKP, SKP};
    play(1, 0, 0);
    build(v);
    play(1, 0, 0);
    chk("skp_cnt", ts_count, 2);
    chk("skp_noerr", saw_e, 0);
    chk("skp_type", os_type, 2'b10);

    // Saturation at MAX_COUNT, then clear with the 20th completion
    step(8'h00, 1'b0, 1'b0, 1'b1);
    build(v);
    repeat (19) play(0, 0, 0);
    chk("sat_cnt", ts_count, MAXC);
    saw_v = 0;
    play(0, 1, 0);
    chk("clr_done_valid", saw_v, 1);
    chk("clr_done_cnt", ts_count, 1);

    // Randomized streams
    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) begin
        v = mk($urandom_range(0, 1) ? T1 : T2, 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 1)), $urandom_range(0, 1) ? 8'h10 : 8'h20,
               8'h02, 8'($urandom_range(0, 1)), -1, 0, 0, 0, 0, 0);
        build(v);
        if ($urandom_range(0, 4) == 0)
          sq[$urandom_range(1, 15)] = rnd_sym();
      end else if (r < 8) begin
        sq = {COM, SKP, SKP};
      end else begin
        sq.delete();
        repeat (5) sq.push_back(rnd_sym());
      end
      play(1, 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_ts_decoder.md
# rx_ts_decoder

Per-lane receive-side ordered-set decoder for the Gen1/Gen2 8-bit PIPE symbol stream. It is the receive counterpart of the transmit OS generator and sits between the PIPE RX data interface and the RX LTSSM. It parses TS1/TS2 ordered sets symbol by symbol and extracts link number, lane number, N_FTS, rate ID and training control. It counts consecutive identical TSs and reports one pulse per completed set; SKP ordered sets are consumed transparently.

## Interface
- MAX_COUNT, 16, saturation value of the consecutive-TS counter.
- COUNT_WIDTH, 5, width of ts_count; must hold MAX_COUNT.
- pclk  in  1  PIPE clock; all logic rises on it.
- reset_n  in  1  asynchronous, active-low reset.
- RxData  in  8  received symbol.
- RxDataK  in  1  1 = K-symbol.
- RxValid  in  1  symbol qualifier; 0 = no symbol this cycle.
- clear  in  1  synchronous; zeroes count and invalidates previous-TS history.
- os_valid  out  1  one-cycle pulse: a well-formed TS completed.
- os_error  out  1  one-cycle pulse: TS aborted on a bad symbol.
- os_type  out  2  01 = TS1, 10 = TS2, 00 = none since reset.
- link_number  out  8  received link field (valid when link_pad = 0).
- link_pad  out  1  link field was PAD.
- lane_number  out  8  received lane field (valid when lane_pad = 0).
- lane_pad  out  1  lane field was PAD.
- n_fts  out  8  symbol 3.
- rate_id  out  8  symbol 4.
- train_ctrl  out  8  symbol 5 (b0 hot reset, b1 disable, b2 loopback, b3 disable scrambling).
- ts_count  out  COUNT_WIDTH  consecutive identical TSs, saturating.

## Operation
- Symbols: COM = 0xBC/K, PAD = 0xF7/K, SKP = 0x1C/K, TS1 ID = 0x4A/D, TS2 ID = 0x45/D.
- A symbol is consumed only when RxValid = 1; with RxValid = 0, state, index and all outputs hold.
- FSM states: HUNT, LINK, LANE, NFTS, RATE, CTRL, ID, SKIP.
- HUNT: COM -> LINK; anything else ignored, no error.
- LINK: PAD -> link_pad = 1; data -> capture value; SKP -> SKIP; other K -> abort.
- LANE: PAD or data captured as in LINK; other K -> abort.
- NFTS, RATE, CTRL: data captured; K -> abort.
- ID: ten symbols, index 0..9.
  - Symbol 0 must be 0x4A or 0x45 data and fixes the type.
  - Symbols 1..9 must equal symbol 0.
  - Any mismatch or K -> abort.
  - Symbol 9 accepted -> complete, -> HUNT.
- SKIP: SKP consumed, stay; COM -> LINK; any other symbol -> HUNT. No error, ts_count untouched.
- COM in LINK..ID (other than where listed above) restarts a new set: -> LINK, partial fields discarded, os_error pulses, ts_count cleared.
- Abort: os_error pulse, ts_count <= 0, history invalid, -> HUNT.
- Completion:
  - Latch all fields and os_type; pulse os_valid.
  - If history is valid and type, link, link_pad, lane, lane_pad, n_fts, rate_id and train_ctrl all equal the last latched set, ts_count <= min(ts_count + 1, MAX_COUNT); else ts_count <= 1.
  - History becomes valid.
- Field outputs change only on completion; an aborted set never alters them.
- clear: ts_count <= 0, history invalid; FSM not disturbed.
  - clear in the same cycle as completion: fields latch, os_valid pulses, ts_count <= 1.
  - clear in the same cycle as abort: ts_count <= 0.

## Timing
- Reset values: every output 0; FSM = HUNT; history invalid.
- Latency: os_valid, os_error, fields and ts_count are registered and appear the cycle after the completing or offending symbol is sampled.
- Minimum TS length is 16 consecutive valid cycles; back-to-back TSs yield os_valid every 16 valid cycles.
- os_valid and os_error are never high together.
- Reset mid-set: immediate return to reset values; a partial set is never reported.

## Test plan
- Reset: assert reset_n = 0 mid-TS, release -> all outputs 0, and the next full TS1 yields os_valid with ts_count = 1.
- Three back-to-back identical TS1 (link PAD, lane PAD, n_fts 0x10, rate 0x02, ctrl 0x00) -> three os_valid pulses 16 cycles apart, ts_count 1, 2, 3, os_type 01, link_pad = lane_pad = 1.
- TS1 (link 0x05, lane 0x03) followed by TS2 with the same fields -> ts_count 1 then 1, os_type 10, link_number 0x05, lane_number 0x03.
- Three TS1 sent, the second with ID symbol 4 = 0x4B -> os_error pulse, ts_count 0, fields unchanged; the third TS1 gives ts_count 1. A COM inserted at ID index 2 -> os_error and restart; the following 15 symbols complete a TS.
- TS2, then COM + 3 SKP, then TS2, with random RxValid = 0 gaps -> ts_count 2, no os_error, outputs stable during gaps.
- 20 identical TS2 with MAX_COUNT = 16 -> ts_count saturates at 16; clear asserted together with the 20th completion -> ts_count 1.
